// File: rtl/core_pkg.sv
// Shared definitions for the instruction-fetch front end.
//   fetch_state_e : prefetch FSM states (BOOT/IDLE/WAIT_GNT/STALE_GNT)
//   WORD_BYTES    : fetch stride in bytes
//   clog2         : ceil(log2(n)), used to size pointers and counters
package core_pkg;

    typedef enum logic [1:0] {
        ST_BOOT      = 2'd0,
        ST_IDLE      = 2'd1,
        ST_WAIT_GNT  = 2'd2,
        ST_STALE_GNT = 2'd3
    } fetch_state_e;

    localparam int unsigned WORD_BYTES = 4;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((32'd1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/prefetch_fifo.sv
// Synchronous FIFO holding fetched instruction words.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   flush      : drop all entries (wins over push/pop in the same cycle)
//   push/wdata : write one entry
//   pop        : retire the head entry
//   rdata      : head entry (meaningful only when !empty)
//   empty      : no entries held
//   count      : number of entries held (0..DEPTH)
module prefetch_fifo
    import core_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 64
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        flush,
    input  logic                        push,
    input  logic [WIDTH-1:0]            wdata,
    input  logic                        pop,
    output logic [WIDTH-1:0]            rdata,
    output logic                        empty,
    output logic [clog2(DEPTH+1)-1:0]   count
);
    localparam int unsigned PTR_W = clog2(DEPTH);
    localparam int unsigned CNT_W = clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;

    assign empty = (count == '0);
    assign full  = (count == CNT_W'(DEPTH));
    assign rdata = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= wdata;
    end

    // Upstream credit accounting must never let a word arrive with no room.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && full && !pop && !flush));

endmodule

// File: rtl/if_prefetch_buffer.sv
// Instruction-fetch prefetch engine for the RV32 pipeline.
// Issues OBI-style requests (req held until gnt), keeps up to MAX_OUTSTANDING
// fetches in flight, buffers returned words in a DEPTH-entry FIFO and drops
// responses belonging to fetches issued before a redirect.
// Ports:
//   clk_i, rst_ni        : clock, asynchronous active-low reset
//   boot_addr_i          : first fetch address after reset
//   fetch_en_i           : allow new bus requests
//   branch_i/addr_i      : redirect pulse and target
//   ready_i/valid_o      : consumer handshake on the head entry
//   rdata_o/addr_o/err_o : head word, its PC, its bus-error flag
//   busy_o               : fetches outstanding or FIFO non-empty
//   instr_*              : imem bus (req/addr/gnt/rvalid/rdata/err)
// Build option: IF_ERR_TRACK_EN stores instr_err_i per entry and drives err_o;
// without it err_o is tied 0.
module if_prefetch_buffer
    import core_pkg::*;
#(
    parameter int unsigned DEPTH           = 4,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] boot_addr_i,
    input  logic        fetch_en_i,
    input  logic        branch_i,
    input  logic [31:0] branch_addr_i,
    input  logic        ready_i,
    output logic        valid_o,
    output logic [31:0] rdata_o,
    output logic [31:0] addr_o,
    output logic        err_o,
    output logic        busy_o,
    output logic        instr_req_o,
    output logic [31:0] instr_addr_o,
    input  logic        instr_gnt_i,
    input  logic        instr_rvalid_i,
    input  logic [31:0] instr_rdata_i,
    input  logic        instr_err_i
);
    localparam int unsigned CNT_W = clog2(DEPTH + 1);
`ifdef IF_ERR_TRACK_EN
    localparam int unsigned FW = 65;
`else
    localparam int unsigned FW = 64;
`endif
    localparam logic [CNT_W-1:0] MAX_OUT_C = CNT_W'(MAX_OUTSTANDING);
    localparam logic [CNT_W:0]   DEPTH_C   = (CNT_W + 1)'(DEPTH);

    fetch_state_e     state, state_next;
    logic [31:0]      fetch_addr;  // next address to request
    logic [31:0]      req_addr;    // address on the bus while req is up
    logic [31:0]      rsp_addr;    // PC of the next response that will be kept
    logic [CNT_W-1:0] outstanding, out_next;
    logic [CNT_W-1:0] discard;
    logic [CNT_W-1:0] fifo_count;
    logic [FW-1:0]    fifo_wdata, fifo_rdata;
    logic             fifo_empty;
    logic             gnt_acc, issue_ok, push, pop, flush, dropping;

    assign instr_req_o  = (state == ST_WAIT_GNT) || (state == ST_STALE_GNT);
    assign instr_addr_o = req_addr;
    assign gnt_acc      = instr_req_o && instr_gnt_i;
    assign dropping     = (discard != '0);

    // FIFO slots are reserved for every in-flight fetch, so a response always has room.
    assign issue_ok = fetch_en_i && (outstanding < MAX_OUT_C) &&
                      (({1'b0, fifo_count} + {1'b0, outstanding}) < DEPTH_C);

    assign flush = branch_i && (state != ST_BOOT);
    assign push  = instr_rvalid_i && !dropping && !branch_i;
    assign pop   = valid_o && ready_i;

    assign out_next = outstanding + CNT_W'(gnt_acc) - CNT_W'(instr_rvalid_i);

    always_comb begin
        state_next = state;
        case (state)
            ST_BOOT:      state_next = ST_IDLE;
            ST_IDLE:      if (issue_ok && !branch_i) state_next = ST_WAIT_GNT;
            ST_WAIT_GNT:  if (instr_gnt_i) state_next = ST_IDLE;
                          else if (branch_i) state_next = ST_STALE_GNT;
            ST_STALE_GNT: if (instr_gnt_i) state_next = ST_IDLE;
            default:      state_next = ST_BOOT;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= ST_BOOT;
            fetch_addr  <= '0;
            req_addr    <= '0;
            rsp_addr    <= '0;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            state       <= state_next;
            outstanding <= out_next;
            if (state == ST_IDLE && state_next == ST_WAIT_GNT) req_addr <= fetch_addr;
            if (state == ST_BOOT) begin
                fetch_addr <= boot_addr_i & ~32'd3;
                rsp_addr   <= boot_addr_i & ~32'd3;
            end else if (branch_i) begin
                // Everything still in flight (including a grant this cycle) is stale.
                fetch_addr <= branch_addr_i & ~32'd3;
                rsp_addr   <= branch_addr_i & ~32'd3;
                discard    <= out_next;
            end else begin
                if (state == ST_WAIT_GNT && instr_gnt_i) fetch_addr <= fetch_addr + WORD_BYTES;
                discard <= discard + CNT_W'(state == ST_STALE_GNT && instr_gnt_i)
                                   - CNT_W'(instr_rvalid_i && dropping);
                if (push) rsp_addr <= rsp_addr + WORD_BYTES;
            end
        end
    end

`ifdef IF_ERR_TRACK_EN
    assign fifo_wdata = {instr_err_i, rsp_addr, instr_rdata_i};
    assign err_o      = !fifo_empty && fifo_rdata[64];
`else
    logic unused_err;
    assign unused_err = instr_err_i;
    assign fifo_wdata = {rsp_addr, instr_rdata_i};
    assign err_o      = 1'b0;
`endif

    prefetch_fifo #(.DEPTH(DEPTH), .WIDTH(FW)) u_fifo (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .flush (flush),
        .push  (push),
        .wdata (fifo_wdata),
        .pop   (pop),
        .rdata (fifo_rdata),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Data outputs read as zero whenever nothing is buffered.
    assign valid_o = !fifo_empty && !branch_i;
    assign rdata_o = fifo_empty ? 32'd0 : fifo_rdata[31:0];
    assign addr_o  = fifo_empty ? 32'd0 : fifo_rdata[63:32];
    assign busy_o  = (outstanding != '0) || !fifo_empty;

endmodule

// File: tb/tb_if_prefetch_buffer.sv
module tb_if_prefetch_buffer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] boot_addr;
    logic        fetch_en, branch, ready;
    logic [31:0] branch_addr;
    logic        valid, err, busy, req;
    logic [31:0] rdata, addr, iaddr;
    logic        gnt, rvalid, ierr;
    logic [31:0] irdata;

    int total = 0;
    int bad   = 0;

    logic [31:0] gq[$];                  // granted addresses in order
    logic [31:0] la[$], ld[$];           // popped addr / data
    logic        le[$];                  // popped err
    int          rd_idx = 0;
    logic        hold = 1'b0;
    logic [31:0] err_addr = 32'h1;

    if_prefetch_buffer #(.DEPTH(4), .MAX_OUTSTANDING(2)) dut (
        .clk_i(clk), .rst_ni(rst_n), .boot_addr_i(boot_addr), .fetch_en_i(fetch_en),
        .branch_i(branch), .branch_addr_i(branch_addr), .ready_i(ready),
        .valid_o(valid), .rdata_o(rdata), .addr_o(addr), .err_o(err), .busy_o(busy),
        .instr_req_o(req), .instr_addr_o(iaddr), .instr_gnt_i(gnt),
        .instr_rvalid_i(rvalid), .instr_rdata_i(irdata), .instr_err_i(ierr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst_n && req && gnt) gq.push_back(iaddr);
        if (rst_n && valid && ready) begin
            la.push_back(addr); ld.push_back(rdata); le.push_back(err);
        end
    end

    // Memory: answers each grant in order one cycle later, data = ~addr.
    always @(negedge clk) begin
        if (!rst_n) begin
            rvalid = 1'b0; ierr = 1'b0; irdata = '0; rd_idx = gq.size();
        end else if (!hold && rd_idx < gq.size()) begin
            rvalid = 1'b1; irdata = ~gq[rd_idx]; ierr = (gq[rd_idx] == err_addr);
            rd_idx++;
        end else begin
            rvalid = 1'b0; ierr = 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic redirect(input logic [31:0] a);
        branch = 1'b1; branch_addr = a; tick(); branch = 1'b0;
    endtask

    task automatic drain();
        fetch_en = 1'b0; ready = 1'b1; gnt = 1'b1; hold = 1'b0;
        for (int k = 0; k < 40 && (busy || req); k++) tick();
        chk("drain_busy", {31'd0, busy}, 32'd0);
    endtask

    logic [31:0] exp_err;
    int s, g0;
    logic seen;

    initial begin
        rst_n = 1'b0; boot_addr = 32'h83; fetch_en = 1'b0; branch = 1'b0;
        branch_addr = '0; ready = 1'b0; gnt = 1'b0;
        #1;
        chk("rst_valid", {31'd0, valid}, 0);
        chk("rst_req",   {31'd0, req},   0);
        chk("rst_iaddr", iaddr, 0);
        chk("rst_busy",  {31'd0, busy},  0);
        chk("rst_addr",  addr,  0);
        tick(); tick();

        // 1: sequential fetch from boot address, one-cycle response latency
        rst_n = 1'b1; gnt = 1'b1; ready = 1'b1; fetch_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            seen = 1'b0;
            for (int k = 0; k < 30 && !seen; k++) begin
                @(negedge clk); #1;
                seen = rvalid;
            end
            chk("t1_rvalid_seen", {31'd0, seen}, 1);
            chk("t1_no_bypass", {31'd0, valid}, 0);
            tick();
            chk("t1_valid", {31'd0, valid}, 1);
            chk("t1_addr", addr, 32'h80 + 32'(i) * 4);
            chk("t1_rdata", rdata, ~(32'h80 + 32'(i) * 4));
        end
        drain();
        chk("t1_gnt2", gq[2], 32'h88);

        // 2: consumer stalled, credits stop requests at DEPTH words
        redirect(32'h400);
        s = la.size(); g0 = gq.size();
        ready = 1'b0; fetch_en = 1'b1;
        repeat (30) tick();
        chk("t2_grants4", gq.size() - g0, 4);
        chk("t2_req_off", {31'd0, req}, 0);
        chk("t2_head", addr, 32'h400);
        ready = 1'b1; tick(); ready = 1'b0;
        repeat (10) tick();
        chk("t2_grants5", gq.size() - g0, 5);
        chk("t2_req_off2", {31'd0, req}, 0);
        drain();
        chk("t2_pops", la.size() - s, 5);
        chk("t2_last", la[s+4], 32'h410);

        // 3: redirect while waiting for a slow grant
        redirect(32'h300);
        s = la.size();
        gnt = 1'b0; fetch_en = 1'b1;
        for (int k = 0; k < 20 && !req; k++) tick();
        chk("t3_req", {31'd0, req}, 1);
        chk("t3_addr0", iaddr, 32'h300);
        tick();
        branch = 1'b1; branch_addr = 32'h200;
        tick();
        branch = 1'b0;
        chk("t3_hold_req", {31'd0, req}, 1);
        chk("t3_hold_addr", iaddr, 32'h300);
        tick();
        chk("t3_hold_addr2", iaddr, 32'h300);
        gnt = 1'b1;
        tick();
        gnt = 1'b0;
        chk("t3_idle", {31'd0, req}, 0);
        for (int k = 0; k < 20 && !req; k++) tick();
        chk("t3_newaddr", iaddr, 32'h200);
        gnt = 1'b1;
        repeat (6) tick();
        drain();
        chk("t3_first", la[s], 32'h200);
        chk("t3_second", la[s+1], 32'h204);

        // 4: two in flight at a redirect to an unaligned target
        redirect(32'h500);
        s = la.size(); g0 = gq.size();
        hold = 1'b1; fetch_en = 1'b1;
        for (int k = 0; k < 20 && gq.size() < g0 + 2; k++) tick();
        repeat (2) tick();
        chk("t4_two_out", gq.size() - g0, 2);
        chk("t4_req_blocked", {31'd0, req}, 0);
        chk("t4_busy", {31'd0, busy}, 1);
        branch = 1'b1; branch_addr = 32'h1002;
        tick();
        branch = 1'b0; hold = 1'b0;
        for (int k = 0; k < 30 && la.size() == s; k++) tick();
        drain();
        chk("t4_first_addr", la[s], 32'h1000);
        chk("t4_first_data", ld[s], ~32'h1000);
        chk("t4_gnt_after", gq[g0+2], 32'h1000);

        // 5: bus error on the second response
        redirect(32'h600);
        s = la.size();
        err_addr = 32'h604; fetch_en = 1'b1;
        for (int k = 0; k < 40 && la.size() < s + 3; k++) tick();
        drain();
        err_addr = 32'h1;
`ifdef IF_ERR_TRACK_EN
        exp_err = 32'd1;
`else
        exp_err = 32'd0;
`endif
        chk("t5_err0", {31'd0, le[s]}, 0);
        chk("t5_err1", {31'd0, le[s+1]}, exp_err);
        chk("t5_err2", {31'd0, le[s+2]}, 0);
        chk("t5_addr1", la[s+1], 32'h604);

        // 6: reset mid-burst, then restart at the new boot address
        redirect(32'h700);
        ready = 1'b0; fetch_en = 1'b1;
        repeat (12) tick();
        chk("t6_pre_valid", {31'd0, valid}, 1);
        boot_addr = 32'hC0;
        rst_n = 1'b0;
        #1;
        chk("t6_valid", {31'd0, valid}, 0);
        chk("t6_busy", {31'd0, busy}, 0);
        chk("t6_req", {31'd0, req}, 0);
        chk("t6_iaddr", iaddr, 0);
        chk("t6_addr", addr, 0);
        chk("t6_rdata", rdata, 0);
        tick(); tick();
        s = la.size(); g0 = gq.size();
        ready = 1'b1;
        rst_n = 1'b1;
        for (int k = 0; k < 30 && la.size() == s; k++) tick();
        drain();
        chk("t6_gnt", gq[g0], 32'hC0);
        chk("t6_first", la[s], 32'hC0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end
endmodule
